// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared constants and types for the matrix-multiply BRAM port arbiter.
//   REQ_HOST/REQ_FETCH/REQ_WB : requester indices
//   NREQ_DEF/AW_DEF/DW_DEF    : default requester count, address and data widths
//   rd_tag_t                  : read-return pipeline entry {valid, id}
package bram_arb_pkg;

    localparam int unsigned REQ_HOST  = 0;
    localparam int unsigned REQ_FETCH = 1;
    localparam int unsigned REQ_WB    = 2;

    localparam int unsigned NREQ_DEF = 3;
    localparam int unsigned AW_DEF   = 8;
    localparam int unsigned DW_DEF   = 64;

    localparam int unsigned ID_W = $clog2(NREQ_DEF);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i  : request vector
//   last_i : index granted last; search starts at last_i+1 and wraps
//   gnt_o  : one-hot grant, zero when no request is pending
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o
);

    // Walk N positions after last_i; the first pending request wins.
    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = (int'(last_i) + k) % int'(N);
            if (!found && req_i[IW'(idx)]) begin
                gnt_o[IW'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port among host loader (0), input fetch (1)
// and result writeback (2). One beat per cycle, round-robin with capped bursts,
// read data returned to the issuer after a fixed tagged latency.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_i/lock_i/we_i   : per-requester request, burst lock, write enable
//   addr_i/wdata_i      : per-requester address / write data, slot i at [i*W +: W]
//   gnt_o               : combinational one-hot grant (beat = req & gnt)
//   rvalid_o, rdata_o   : read-return valid per requester, shared data (dout passthrough)
//   en/wea/addr/din_bram_o, dout_bram_i : registered BRAM pins
// Optional BRAM_ARB_PERF_EN adds perf_clr_i, perf_gnt_o, perf_stall_o counters.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
`ifdef BRAM_ARB_PERF_EN
    input  logic               perf_clr_i,
    output logic [NREQ*32-1:0] perf_gnt_o,
    output logic [NREQ*32-1:0] perf_stall_o,
`endif
    output logic               en_bram_o,
    output logic               wea_bram_o,
    output logic [AW-1:0]      addr_bram_o,
    output logic [DW-1:0]      din_bram_o,
    input  logic [DW-1:0]      dout_bram_i
);

    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] BMAX = BCW'(MAX_BURST - 1);

    logic [IW-1:0]   owner_q, owner_d;
    logic            lock_q, lock_d;
    logic [BCW-1:0]  cnt_q, cnt_d;

    logic            en_q, en_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;

    rd_tag_t         tag_d;
    rd_tag_t         pipe_q [RD_LAT+1];

    logic [NREQ-1:0] rr_gnt;
    logic            locked_win;
    logic            beat;
    logic [IW-1:0]   gidx;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req_i  (req_i),
        .last_i (owner_q),
        .gnt_o  (rr_gnt)
    );

    // Locked owner keeps the port while it still requests and the burst cap is not hit.
    always_comb begin
        locked_win = lock_q && req_i[owner_q] && (cnt_q < BMAX);
        gnt_o      = locked_win ? (NREQ'(1) << owner_q) : rr_gnt;
    end

    // Encode the granted index.
    always_comb begin
        beat = |gnt_o;
        gidx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_o[i]) gidx = IW'(i);
        end
    end

    // Next-state for arbitration state, BRAM pins and read tag.
    always_comb begin
        owner_d = owner_q;
        lock_d  = 1'b0;
        cnt_d   = '0;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        tag_d   = '0;
        if (beat) begin
            owner_d = gidx;
            lock_d  = lock_i[gidx];
            // Count only continuation beats of a locked burst; saturate so a lone owner keeps winning.
            if (lock_q && (gidx == owner_q) && lock_i[gidx]) begin
                cnt_d = (cnt_q == BMAX) ? cnt_q : cnt_q + BCW'(1);
            end
            en_d        = 1'b1;
            we_d        = we_i[gidx];
            addr_d      = addr_i[gidx*AW +: AW];
            din_d       = wdata_i[gidx*DW +: DW];
            tag_d.valid = !we_i[gidx];
            tag_d.id    = ID_W'(gidx);
        end
    end

    // State and pin registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= IW'(NREQ - 1);
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            owner_q <= owner_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Read-return tag pipeline: stage 0 aligns with the pins, last stage with dout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= RD_LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= tag_d;
            for (int unsigned k = 1; k <= RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (pipe_q[RD_LAT].valid) rvalid_o[pipe_q[RD_LAT].id] = 1'b1;
    end

    assign rdata_o     = dout_bram_i;
    assign en_bram_o   = en_q;
    assign wea_bram_o  = we_q;
    assign addr_bram_o = addr_q;
    assign din_bram_o  = din_q;

`ifdef BRAM_ARB_PERF_EN
    // Saturating per-requester beat and stall counters; clear beats increment.
    for (genvar i = 0; i < int'(NREQ); i++) begin : g_perf
        logic [31:0] gnt_cnt_q;
        logic [31:0] stall_cnt_q;

        always_ff @(posedge clk) begin
            if (!rst_n || perf_clr_i) begin
                gnt_cnt_q   <= '0;
                stall_cnt_q <= '0;
            end else begin
                if (gnt_o[i] && (gnt_cnt_q != '1)) gnt_cnt_q <= gnt_cnt_q + 32'd1;
                if (req_i[i] && !gnt_o[i] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end

        assign perf_gnt_o[i*32 +: 32]   = gnt_cnt_q;
        assign perf_stall_o[i*32 +: 32] = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: self-checking bench for bram_port_arbiter with a BRAM model
// and a read-return scoreboard.
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int unsigned NREQ      = 3;
    localparam int unsigned AW        = 8;
    localparam int unsigned DW        = 64;
    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned MAX_BURST = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req, lock, we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt, rvalid;
    logic [DW-1:0]      rdata;
    logic               en_b, wea_b;
    logic [AW-1:0]      addr_b;
    logic [DW-1:0]      din_b, dout_b;
`ifdef BRAM_ARB_PERF_EN
    logic               perf_clr = 1'b0;
    logic [NREQ*32-1:0] perf_gnt, perf_stall;
`endif

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
`ifdef BRAM_ARB_PERF_EN
        .perf_clr_i  (perf_clr),
        .perf_gnt_o  (perf_gnt),
        .perf_stall_o(perf_stall),
`endif
        .en_bram_o   (en_b),
        .wea_bram_o  (wea_b),
        .addr_bram_o (addr_b),
        .din_bram_o  (din_b),
        .dout_bram_i (dout_b)
    );

    function automatic logic [63:0] pat(input int a);
        return {32'hC0DE_0000 | 32'(a), 32'(a) * 32'h0101_0101};
    endfunction

    // BRAM model, read-first, one-cycle read latency
    logic [63:0] mem     [256];
    logic [63:0] ref_mem [256];
    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a]     = pat(a);
            ref_mem[a] = pat(a);
        end
    end
    always @(posedge clk) begin
        if (en_b) begin
            if (wea_b) mem[addr_b] <= din_b;
            dout_b <= mem[addr_b];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] id1h;
        logic [63:0] data;
    } rd_exp_t;
    rd_exp_t sbq[$];

    int          cyc     = 0;
    logic        exp_en  = 1'b0;
    logic        exp_we  = 1'b0;
    logic [7:0]  exp_addr = '0;
    logic [63:0] exp_din  = '0;

    // Monitor: pins, read returns and grant legality, sampled on the falling edge.
    always @(negedge clk) begin : mon
        rd_exp_t e;
        int      gi;
        logic    legal;
        cyc++;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            check_eq("rvalid", 64'(rvalid), 64'(e.id1h));
            check_eq("rdata", rdata, e.data);
        end else begin
            check_eq("rvalid_idle", 64'(rvalid), 64'd0);
        end
        check_eq("en_bram", 64'(en_b), 64'(exp_en));
        check_eq("wea_bram", 64'(wea_b), 64'(exp_we));
        check_eq("addr_bram", 64'(addr_b), 64'(exp_addr));
        check_eq("din_bram", din_b, exp_din);
        if (!rst_n) begin
            exp_en   = 1'b0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_din  = '0;
            sbq.delete();
        end else begin
            legal = ($countones(gnt) <= 1) && ((gnt & ~req) == '0);
            check_eq("gnt_legal", 64'(legal), 64'd1);
            gi = -1;
            for (int i = 0; i < 3; i++) if (gnt[i]) gi = i;
            exp_en = (gi >= 0);
            exp_we = 1'b0;
            if (gi >= 0) begin
                exp_we   = we[gi];
                exp_addr = addr[gi*8 +: 8];
                exp_din  = wdata[gi*64 +: 64];
                if (we[gi]) begin
                    ref_mem[exp_addr] = exp_din;
                end else begin
                    e.cyc  = cyc + 1 + int'(RD_LAT);
                    e.id1h = 3'b001 << gi;
                    e.data = ref_mem[exp_addr];
                    sbq.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input string tag, input logic [2:0] e);
        @(negedge clk);
        check_eq(tag, 64'(gnt), 64'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check_eq("rst_en", 64'(en_b), 64'd0);
        check_eq("rst_wea", 64'(wea_b), 64'd0);
        check_eq("rst_addr", 64'(addr_b), 64'd0);
        check_eq("rst_din", din_b, 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        step();

        // single read by fetch
        req[REQ_FETCH] = 1'b1;
        addr[15:8]     = 8'h10;
        exp_gnt("single_gnt", 3'b010);
        step();
        req = '0;
        @(negedge clk);
        check_eq("single_en", 64'(en_b), 64'd1);
        check_eq("single_wea", 64'(wea_b), 64'd0);
        check_eq("single_addr", 64'(addr_b), 64'h10);
        step();
        @(negedge clk);
        check_eq("single_rvalid", 64'(rvalid), 64'(3'b010));
        check_eq("single_rdata", rdata, pat(8'h10));
        repeat (3) step();

        // contention from reset: 0,1,2,0,1,2
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        addr  = {8'h22, 8'h21, 8'h20};
        req   = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_gnt($sformatf("rr%0d", k), 3'b001 << (k % 3));
            step();
        end
        req = '0;
        repeat (3) step();

        // locked burst of 8 by fetch with writeback pending
        req         = 3'b110;
        lock        = 3'b010;
        addr[23:16] = 8'h30;
        for (int k = 0; k < 8; k++) begin
            addr[15:8] = 8'(k);
            exp_gnt($sformatf("burst%0d", k), 3'b010);
            step();
        end
        req[REQ_FETCH] = 1'b0;
        lock           = '0;
        exp_gnt("burst_release", 3'b100);
        step();
        req = '0;
        repeat (3) step();

        // starvation cap: host locked for 20 beats, writeback pending
        addr[23:16] = 8'h60;
        for (int c = 0; c <= 20; c++) begin
            req[REQ_HOST]  = 1'b1;
            lock[REQ_HOST] = 1'b1;
            req[REQ_WB]    = (c <= 16);
            addr[7:0]      = 8'(8'h40 + c);
            exp_gnt($sformatf("cap%0d", c), (c == 16) ? 3'b100 : 3'b001);
            step();
        end
        req  = '0;
        lock = '0;
        repeat (3) step();

        // write by writeback, then read back by host
        req           = 3'b100;
        we            = 3'b100;
        addr[23:16]   = 8'hFF;
        wdata[191:128] = 64'hA5A5_0000_FFFF_1234;
        exp_gnt("wr_gnt", 3'b100);
        step();
        req       = 3'b001;
        we        = '0;
        addr[7:0] = 8'hFF;
        exp_gnt("rd_after_wr_gnt", 3'b001);
        check_eq("wr_wea", 64'(wea_b), 64'd1);
        check_eq("wr_no_rvalid", 64'(rvalid), 64'd0);
        step();
        req = '0;
        step();
        @(negedge clk);
        check_eq("wr_rd_rvalid", 64'(rvalid), 64'(3'b001));
        check_eq("wr_rd_data", rdata, 64'hA5A5_0000_FFFF_1234);
        repeat (2) step();

        // reset with reads in flight
        req       = 3'b001;
        addr[7:0] = 8'h01;
        exp_gnt("rst_rd0_gnt", 3'b001);
        step();
        req        = 3'b010;
        addr[15:8] = 8'h02;
        rst_n      = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 3'b111;
        exp_gnt("rst_next_gnt", 3'b001);
        check_eq("rst_mid_en", 64'(en_b), 64'd0);
        check_eq("rst_mid_addr", 64'(addr_b), 64'd0);
        check_eq("rst_mid_rvalid", 64'(rvalid), 64'd0);
        step();
        req = '0;
        repeat (4) step();

        check_eq("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
